// File: rtl/digit_serializer.sv
// Parallel-load, serial-out digit streamer with valid/ready handshake.
// Emits the packed digit word MSD-first or LSD-first and pulses done after the last transfer.
module digit_serializer #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   trig,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   dir,
  input  logic [COUNT*WIDTH-1:0] in,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IW = $clog2(COUNT);
  localparam logic [IW-1:0] LastIdx = IW'(COUNT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                 r_state;
  logic [COUNT*WIDTH-1:0] r_shadow;
  logic                   r_dir;
  logic [IW-1:0]          r_idx;

  logic [IW-1:0]    w_next_idx;
  logic [WIDTH-1:0] w_next_digit;
  logic [WIDTH-1:0] w_first_digit;

  // Stream position idx maps to digit idx (LSD first) or COUNT-1-idx (MSD first).
  function automatic logic [WIDTH-1:0] f_digit(input logic [COUNT*WIDTH-1:0] word,
                                               input logic d, input logic [IW-1:0] idx);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int unsigned k = 0; k < COUNT; k++) begin
      if ((d ? k : (COUNT - 1 - k)) == 32'(idx)) res = word[k*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  always_comb begin
    w_next_idx    = r_idx + IW'(1);
    w_next_digit  = f_digit(r_shadow, r_dir, w_next_idx);
    w_first_digit = f_digit(in, dir, '0);
  end

  always_ff @(posedge trig or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_shadow  <= '0;
      r_dir     <= 1'b0;
      r_idx     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          done      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (load) begin
            r_shadow  <= in;
            r_dir     <= dir;
            r_idx     <= '0;
            out       <= w_first_digit;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            r_state   <= StSend;
          end else begin
            busy    <= 1'b0;
            r_state <= StIdle;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (r_idx == LastIdx) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              r_state   <= StDone;
            end else begin
              r_idx    <= w_next_idx;
              out      <= w_next_digit;
              out_last <= (w_next_idx == LastIdx);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serializer.sv
// Bench for digit_serializer: queue-based stream model checked every cycle, plus
// directed words with literal expected digit streams and done timing.
module tb_digit_serializer;
  localparam int unsigned COUNT = 4;
  localparam int unsigned WIDTH = 4;

  logic                   trig = 1'b0;
  logic                   reset = 1'b1;
  logic                   load = 1'b0;
  logic                   dir = 1'b0;
  logic [COUNT*WIDTH-1:0] in = '0;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out;
  logic                   out_valid, out_last, busy, done;

  digit_serializer #(.COUNT(COUNT), .WIDTH(WIDTH)) dut (
    .trig(trig), .reset(reset), .load(load), .dir(dir), .in(in), .out_ready(out_ready),
    .out(out), .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 trig = ~trig;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [WIDTH-1:0] col[$];

  // Model: digits still owed to the consumer, the digit last shown, and the done pulse.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_out = '0;
  bit               m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge trig or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_out  = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_q.size() > 0) begin
        if (out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1'b1;
          else m_out = m_q[0];
        end
      end else if (load) begin
        for (int k = 0; k < COUNT; k++)
          m_q.push_back(dir ? in[k*WIDTH +: WIDTH] : in[(COUNT-1-k)*WIDTH +: WIDTH]);
        m_out = m_q[0];
      end
    end
  end

  always @(negedge trig) begin
    if (chk_en && !reset) begin
      chk("model_out", 32'(out), 32'(m_out));
      chk("model_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("model_last", 32'(out_last), 32'(m_q.size() == 1));
      chk("model_busy", 32'(busy), 32'((m_q.size() > 0) || m_done));
      chk("model_done", 32'(done), 32'(m_done));
      if (out_valid && out_ready) col.push_back(out);
    end
  end

  task automatic tick();
    @(posedge trig);
    #2;
  endtask

  // exp_stream lists the expected digits in transfer order, first digit in the top nibble.
  task automatic run_word(input logic [15:0] word, input logic d, input int stall,
                          input bit mid_load, input logic [15:0] exp_stream, input int exp_done);
    int n;
    bit seen;
    col.delete();
    in = word;
    dir = d;
    load = 1'b1;
    out_ready = (stall == 0);
    tick();
    load = 1'b0;
    n = 1;
    seen = 1'b0;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_digit", 32'(out), 32'(exp_stream[15:12]));
    while (!seen && n < 40) begin
      if (n <= stall) chk("stall_hold", 32'(out), 32'(exp_stream[15:12]));
      if (n == stall + 1) out_ready = 1'b1;
      if (mid_load && n == 2) begin
        load = 1'b1;
        in = 16'hFFFF;
      end
      if (mid_load && n == 3) begin
        load = 1'b0;
        in = word;
      end
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk("done_cycle", 32'(n), 32'(exp_done));
    chk("stream_len", 32'(col.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("stream_digit", (i < col.size()) ? 32'(col[i]) : 32'hDEAD,
          32'(exp_stream[(3-i)*4 +: 4]));
  endtask

  task automatic wait_idle();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    run_word(16'h1234, 1'b0, 0, 1'b0, 16'h1234, 5);
    wait_idle();
    run_word(16'h1234, 1'b1, 0, 1'b0, 16'h4321, 5);
    wait_idle();
    run_word(16'hA5C3, 1'b0, 3, 1'b0, 16'hA5C3, 8);
    wait_idle();
    run_word(16'h1234, 1'b0, 0, 1'b1, 16'h1234, 5);
    wait_idle();
    // Second load lands in the DONE cycle of the first word.
    run_word(16'h1234, 1'b0, 0, 1'b0, 16'h1234, 5);
    run_word(16'h0987, 1'b0, 0, 1'b0, 16'h0987, 5);
    wait_idle();

    // Asynchronous reset mid-word, after two digits have transferred.
    in = 16'h1234;
    dir = 1'b0;
    out_ready = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("pre_rst_digit", 32'(out), 32'h3);
    #1 reset = 1'b1;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    chk("arst_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    run_word(16'h1234, 1'b0, 0, 1'b0, 16'h1234, 5);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
